// File: rtl/fetch_pkg.sv
// Shared types and sizing helpers for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  // ADDI x0, x0, 0 used to fill IF/ID bubbles
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  // One BTB line; tag stored zero-extended to XLEN
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] tag;
    logic [XLEN-1:0] target;
    logic [1:0]      ctr;
  } btb_entry_t;

  function automatic int unsigned idx_w(input int unsigned entries);
    return $clog2(entries);
  endfunction

  function automatic int unsigned tag_w(input int unsigned dw, input int unsigned entries);
    return dw - idx_w(entries) - 2;
  endfunction

endpackage

// File: rtl/fetch_stage_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
module btb
  import fetch_pkg::*;
#(
  parameter int unsigned BTB_ENTRIES = 16,
  parameter int unsigned DATA_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] lookup_pc_i,
  output logic                  lookup_taken_c,
  output logic [DATA_WIDTH-1:0] lookup_target_c,
  input  logic                  update_en_i,
  input  logic [DATA_WIDTH-1:0] update_pc_i,
  input  logic                  update_taken_i,
  input  logic [DATA_WIDTH-1:0] update_target_i
);

  localparam int unsigned IDX_W = idx_w(BTB_ENTRIES);
  localparam int unsigned TAG_W = tag_w(DATA_WIDTH, BTB_ENTRIES);

  btb_entry_t mem_q [BTB_ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  btb_entry_t       lk_e;
  btb_entry_t       up_e;
  btb_entry_t       up_entry_d;
  logic             up_we;
  logic             up_hit;
  logic             unused_pc_bits;

  assign lk_idx = lookup_pc_i[IDX_W+1:2];
  assign lk_tag = lookup_pc_i[DATA_WIDTH-1:IDX_W+2];
  assign up_idx = update_pc_i[IDX_W+1:2];
  assign up_tag = update_pc_i[DATA_WIDTH-1:IDX_W+2];
  assign lk_e   = mem_q[lk_idx];
  assign up_e   = mem_q[up_idx];
  assign unused_pc_bits = ^{lookup_pc_i[1:0], update_pc_i[1:0]};

  // Lookup reads pre-update contents; predict taken on hit with ctr MSB set
  always_comb begin
    lookup_taken_c  = lk_e.valid && (lk_e.tag == XLEN'(lk_tag)) && lk_e.ctr[1];
    lookup_target_c = DATA_WIDTH'(lk_e.target);
  end

  // Training: saturating counter on hit, allocate on taken miss
  always_comb begin
    up_entry_d = up_e;
    up_we      = 1'b0;
    up_hit     = up_e.valid && (up_e.tag == XLEN'(up_tag));
    if (update_en_i) begin
      if (up_hit) begin
        up_we = 1'b1;
        if (update_taken_i) begin
          if (up_e.ctr != 2'b11) up_entry_d.ctr = up_e.ctr + 2'd1;
          up_entry_d.target = XLEN'(update_target_i);
        end else begin
          if (up_e.ctr != 2'b00) up_entry_d.ctr = up_e.ctr - 2'd1;
        end
      end else if (update_taken_i) begin
        up_we             = 1'b1;
        up_entry_d.valid  = 1'b1;
        up_entry_d.tag    = XLEN'(up_tag);
        up_entry_d.target = XLEN'(update_target_i);
        up_entry_d.ctr    = 2'b10;
      end
    end
  end

  // Storage; reset only invalidates lines
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(BTB_ENTRIES); i++) mem_q[i].valid <= 1'b0;
    end else if (up_we) begin
      mem_q[up_idx] <= up_entry_d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, BTB-predicted next PC, IF/ID register.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0,
  parameter int unsigned BTB_ENTRIES  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_f,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  input  logic                  update_en,
  input  logic [DATA_WIDTH-1:0] update_pc,
  input  logic                  update_taken,
  input  logic [DATA_WIDTH-1:0] update_target,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] instr_d,
  output logic [DATA_WIDTH-1:0] pc_d,
  output logic [DATA_WIDTH-1:0] pc_plus4_d,
  output logic                  pred_taken_d,
  output logic                  valid_d
);

  logic [DATA_WIDTH-1:0] pc_f_q, pc_f_d;
  logic [DATA_WIDTH-1:0] pc_plus4_c;
  logic [DATA_WIDTH-1:0] pred_target_c;
  logic                  pred_taken_c;
  logic [DATA_WIDTH-1:0] ifid_instr_q, ifid_instr_d;
  logic [DATA_WIDTH-1:0] ifid_pc_q, ifid_pc_d;
  logic [DATA_WIDTH-1:0] ifid_pc4_q, ifid_pc4_d;
  logic                  ifid_pt_q, ifid_pt_d;
  logic                  ifid_valid_q, ifid_valid_d;

  btb #(
    .BTB_ENTRIES(BTB_ENTRIES),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_btb (
    .clk            (clk),
    .rst            (rst),
    .lookup_pc_i    (pc_f_q),
    .lookup_taken_c (pred_taken_c),
    .lookup_target_c(pred_target_c),
    .update_en_i    (update_en),
    .update_pc_i    (update_pc),
    .update_taken_i (update_taken),
    .update_target_i(update_target)
  );

  assign pc_plus4_c = pc_f_q + DATA_WIDTH'(4);

  // Next PC and IF/ID contents: redirect beats stall, stall holds everything
  always_comb begin
    pc_f_d       = pc_f_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_pt_d    = ifid_pt_q;
    ifid_valid_d = ifid_valid_q;
    if (redirect) begin
      pc_f_d       = redirect_pc;
      ifid_instr_d = DATA_WIDTH'(NOP);
      ifid_pc_d    = '0;
      ifid_pc4_d   = '0;
      ifid_pt_d    = 1'b0;
      ifid_valid_d = 1'b0;
    end else if (!stall_f) begin
      pc_f_d       = pred_taken_c ? pred_target_c : pc_plus4_c;
      ifid_instr_d = imem_rdata;
      ifid_pc_d    = pc_f_q;
      ifid_pc4_d   = pc_plus4_c;
      ifid_pt_d    = pred_taken_c;
      ifid_valid_d = 1'b1;
    end
  end

  // PC and IF/ID registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_f_q       <= DATA_WIDTH'(RESET_VECTOR);
      ifid_instr_q <= DATA_WIDTH'(NOP);
      ifid_pc_q    <= '0;
      ifid_pc4_q   <= '0;
      ifid_pt_q    <= 1'b0;
      ifid_valid_q <= 1'b0;
    end else begin
      pc_f_q       <= pc_f_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_pt_q    <= ifid_pt_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign imem_addr    = pc_f_q;
  assign instr_d      = ifid_instr_q;
  assign pc_d         = ifid_pc_q;
  assign pc_plus4_d   = ifid_pc4_q;
  assign pred_taken_d = ifid_pt_q;
  assign valid_d      = ifid_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed table, corner sequences, random vs model.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall_f;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        update_en;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic        pred_taken_d;
  logic        valid_d;

  int checks;
  int failures;

  fetch_stage #(
    .DATA_WIDTH  (32),
    .RESET_VECTOR(32'h0),
    .BTB_ENTRIES (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_f      (stall_f),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .update_en    (update_en),
    .update_pc    (update_pc),
    .update_taken (update_taken),
    .update_target(update_target),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .instr_d      (instr_d),
    .pc_d         (pc_d),
    .pc_plus4_d   (pc_plus4_d),
    .pred_taken_d (pred_taken_d),
    .valid_d      (valid_d)
  );

  // Instruction memory: a recognisable pattern derived from the address
  assign imem_rdata = imem_addr ^ 32'hC0DE_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural state of the fetch stage and BTB
  logic [31:0] m_pc, m_instr, m_pcd, m_pc4;
  logic        m_pt, m_vd;
  logic        bv  [16];
  logic [31:0] bt  [16];
  logic [31:0] btg [16];
  int          bc  [16];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic apply(input logic r, input logic s, input logic rd, input logic [31:0] rpc,
                       input logic ue, input logic [31:0] upc, input logic ut,
                       input logic [31:0] utg);
    int unsigned li, ui;
    logic        hit, pt, uhit;
    logic [31:0] pred;
    @(negedge clk);
    rst = r; stall_f = s; redirect = rd; redirect_pc = rpc;
    update_en = ue; update_pc = upc; update_taken = ut; update_target = utg;
    // prediction from the pre-update BTB
    li   = (m_pc >> 2) % 16;
    hit  = bv[li] && (bt[li] == (m_pc >> 6));
    pt   = hit && (bc[li] >= 2);
    pred = pt ? btg[li] : m_pc + 32'd4;
    if (r || rd) begin
      m_instr = 32'h0000_0013; m_pcd = 0; m_pc4 = 0; m_pt = 0; m_vd = 0;
      m_pc = r ? 32'h0 : rpc;
    end else if (!s) begin
      m_instr = m_pc ^ 32'hC0DE_0000; m_pcd = m_pc; m_pc4 = m_pc + 32'd4;
      m_pt = pt; m_vd = 1; m_pc = pred;
    end
    if (r) begin
      for (int i = 0; i < 16; i++) bv[i] = 1'b0;
    end else if (ue) begin
      ui   = (upc >> 2) % 16;
      uhit = bv[ui] && (bt[ui] == (upc >> 6));
      if (uhit) begin
        if (ut) begin
          bc[ui]  = (bc[ui] == 3) ? 3 : bc[ui] + 1;
          btg[ui] = utg;
        end else begin
          bc[ui] = (bc[ui] == 0) ? 0 : bc[ui] - 1;
        end
      end else if (ut) begin
        bv[ui] = 1'b1; bt[ui] = upc >> 6; btg[ui] = utg; bc[ui] = 2;
      end
    end
    @(posedge clk);
    #1;
    check("mdl_imem_addr", imem_addr, m_pc);
    check("mdl_valid_d", 32'(valid_d), 32'(m_vd));
    check("mdl_instr_d", instr_d, m_instr);
    check("mdl_pc_d", pc_d, m_pcd);
    check("mdl_pc_plus4_d", pc_plus4_d, m_pc4);
    check("mdl_pred_taken_d", 32'(pred_taken_d), 32'(m_pt));
  endtask

  task automatic step();
    apply(0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic go(input logic [31:0] pc);
    apply(0, 0, 1, pc, 0, 0, 0, 0);
  endtask
  task automatic train(input logic [31:0] pc, input logic t, input logic [31:0] tg);
    apply(0, 0, 0, 0, 1, pc, t, tg);
  endtask

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pcd;
  } vec_t;

  vec_t vecs [12];

  initial begin
    checks = 0; failures = 0;
    rst = 1; stall_f = 0; redirect = 0; redirect_pc = 0;
    update_en = 0; update_pc = 0; update_taken = 0; update_target = 0;
    m_pc = 0; m_instr = 32'h13; m_pcd = 0; m_pc4 = 0; m_pt = 0; m_vd = 0;
    for (int i = 0; i < 16; i++) begin
      bv[i] = 0; bt[i] = 0; btg[i] = 0; bc[i] = 0;
    end

    // sequential fetch, 3-cycle stall at 0x10, redirect+stall, plain redirect
    vecs[0]  = '{0, 0, 32'h0,   32'h04,  1, 32'h00};
    vecs[1]  = '{0, 0, 32'h0,   32'h08,  1, 32'h04};
    vecs[2]  = '{0, 0, 32'h0,   32'h0C,  1, 32'h08};
    vecs[3]  = '{0, 0, 32'h0,   32'h10,  1, 32'h0C};
    vecs[4]  = '{1, 0, 32'h0,   32'h10,  1, 32'h0C};
    vecs[5]  = '{1, 0, 32'h0,   32'h10,  1, 32'h0C};
    vecs[6]  = '{1, 0, 32'h0,   32'h10,  1, 32'h0C};
    vecs[7]  = '{0, 0, 32'h0,   32'h14,  1, 32'h10};
    vecs[8]  = '{1, 1, 32'h200, 32'h200, 0, 32'h00};
    vecs[9]  = '{0, 0, 32'h0,   32'h204, 1, 32'h200};
    vecs[10] = '{0, 1, 32'h3C,  32'h3C,  0, 32'h00};
    vecs[11] = '{0, 0, 32'h0,   32'h40,  1, 32'h3C};

    // reset state
    apply(1, 0, 0, 0, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 0, 0, 0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_valid_d", 32'(valid_d), 32'h0);
    check("rst_instr_d", instr_d, 32'h0000_0013);
    check("rst_pc_d", pc_d, 32'h0);
    check("rst_pred_taken_d", 32'(pred_taken_d), 32'h0);

    foreach (vecs[k]) begin
      apply(0, vecs[k].stall, vecs[k].redir, vecs[k].rpc, 0, 0, 0, 0);
      check($sformatf("tbl%0d_imem_addr", k), imem_addr, vecs[k].exp_addr);
      check($sformatf("tbl%0d_valid_d", k), 32'(valid_d), 32'(vecs[k].exp_valid));
      check($sformatf("tbl%0d_pc_d", k), pc_d, vecs[k].exp_pcd);
    end
    check("stall_resume_instr_d", instr_d, 32'h3C ^ 32'hC0DE_0000);

    // BTB learning: one taken update makes 0x40 predict 0x100
    apply(0, 0, 1, 32'h20, 1, 32'h40, 1, 32'h100);
    go(32'h40);
    step();
    check("learn_imem_addr", imem_addr, 32'h100);
    check("learn_pc_d", pc_d, 32'h40);
    check("learn_pred_taken_d", 32'(pred_taken_d), 32'h1);

    // two not-taken updates drop the counter to 00
    train(32'h40, 0, 0);
    train(32'h40, 0, 0);
    go(32'h40);
    step();
    check("unlearn_imem_addr", imem_addr, 32'h44);
    check("unlearn_pred_taken_d", 32'(pred_taken_d), 32'h0);

    // aliasing: 0x80 shares the index of 0x40 and evicts it
    train(32'h80, 1, 32'h300);
    go(32'h40);
    step();
    check("alias_imem_addr", imem_addr, 32'h44);

    // saturation: four taken then one not-taken still predicts taken
    for (int i = 0; i < 4; i++) train(32'h80, 1, 32'h300);
    train(32'h80, 0, 0);
    go(32'h80);
    // same-cycle update to the entry being looked up: old prediction wins
    train(32'h80, 0, 0);
    check("samecyc_imem_addr", imem_addr, 32'h300);
    check("samecyc_pred_taken_d", 32'(pred_taken_d), 32'h1);
    go(32'h80);
    step();
    check("after_update_imem_addr", imem_addr, 32'h84);

    // PC wrap with no BTB hit
    go(32'hFFFF_FFFC);
    step();
    check("wrap_imem_addr", imem_addr, 32'h0);
    check("wrap_pc_d", pc_d, 32'hFFFF_FFFC);
    check("wrap_pc_plus4_d", pc_plus4_d, 32'h0);

    // reset mid-stream drops the pending update and clears the BTB
    train(32'h40, 1, 32'h500);
    apply(1, 0, 0, 0, 1, 32'h80, 1, 32'h600);
    check("midrst_imem_addr", imem_addr, 32'h0);
    check("midrst_valid_d", 32'(valid_d), 32'h0);
    go(32'h40);
    step();
    check("midrst_btb_cleared", imem_addr, 32'h44);

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      apply($urandom_range(0, 99) == 0,
            $urandom_range(0, 4) == 0,
            $urandom_range(0, 9) == 0,
            32'($urandom_range(0, 63)) << 2,
            $urandom_range(0, 1) == 1,
            32'($urandom_range(0, 63)) << 2,
            $urandom_range(0, 2) != 0,
            32'($urandom_range(0, 63)) << 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
